hero_burst_arbiter: RTL and testbench
=====================================

// Module: hero_burst_arbiter
// PURPOSE
// - Multi-channel successor to the single hero write path: NUM_CH producers push hero write beats framed by CYCLE_TYPE.
// - Each channel is buffered in its own DEPTH-entry FIFO.
// - Beats are merged onto one registered hero output bus with packet-granular round-robin arbitration.
// - A packet is never interleaved with another.
// - Sits between per-engine hero write generators and the single hero bus master.
// PARAMETERS
// - NUM_CH      4          number of input channels, 2..16
// - DATA_W      32         hero write payload width (hero::HERO_WIDTH)
// - DEPTH       4          per-channel FIFO entries, power of 2, >=2
// - TIMEOUT     64         idle cycles on a locked, empty channel before forced release; 0 disables
// - CH_W        $clog2(NUM_CH) channel index width (derived, do not override)
// PORTS
// - clk         in   1              clock
// - rst_n       in   1              asynchronous active-low reset
// - in_valid    in   NUM_CH         per-channel beat valid
// - in_ready    out  NUM_CH         per-channel FIFO not full
// - in_data     in   NUM_CH*DATA_W  per-channel payload, channel i at [i*DATA_W +: DATA_W]
// - in_cycle    in   NUM_CH*2       per-channel CYCLE_TYPE: IDLE=2'd0, VALID=2'd1, DONE=2'd2, 2'd3 reserved
// - out_valid   out  1              output beat valid
// - out_ready   in   1              downstream accept
// - out_data    out  DATA_W         output payload
// - out_cycle   out  2              output CYCLE_TYPE (VALID or DONE only)
// - out_ch      out  CH_W           source channel of output beat
// - err_drop    out  NUM_CH         1-cycle pulse: accepted handshake with IDLE/reserved cycle type, beat discarded
// - err_timeout out  1              1-cycle pulse: lock force-released by timeout
// BEHAVIOUR
// Reset and input side
// - Reset (async assert, sync deassert by the reset synchroniser upstream) clears all state.
// - After reset: FIFOs empty; in_ready all 1; out_valid 0; out_data 0; out_cycle IDLE; out_ch 0.
// - After reset: err_* 0; FSM ARB; rr pointer = NUM_CH-1, so channel 0 has first priority.
// - Push on in_valid[i] & in_ready[i] when in_cycle is VALID or DONE.
// - Otherwise the beat is consumed and dropped, and err_drop[i] pulses the next cycle.
// - in_ready[i] = !full[i]; a same-cycle pop does not open a full FIFO.
// Output register and handshake
// - Output register loads when !out_valid | out_ready.
// - out_* are held stable while out_valid & !out_ready.
// - Latency: beat pushed in cycle N into an empty FIFO with the arbiter free -> out_valid in cycle N+2.
// - Throughput is 1 beat/cycle while out_ready=1.
// FSM
// - ARB: when the output register can load and any FIFO is non-empty, grant the first non-empty channel after the rr pointer (wrap NUM_CH-1 -> 0).
//   - Pop its head; rr pointer <= granted channel.
//   - A popped VALID beat -> BURST(lock=ch).
//   - A popped DONE beat (single-beat packet) -> stay ARB.
// - BURST: pop only from the locked channel whenever it is non-empty and the output register can load; other channels wait.
//   - A popped DONE beat -> ARB.
//   - Locked FIFO empty: idle counter increments each cycle; reset on any pop.
//   - Counter == TIMEOUT-1 with FIFO still empty: pulse err_timeout and -> ARB; the remainder of that packet later arbitrates as a new packet.
// Boundaries
// - Simultaneous push and pop on the same non-full FIFO: both occur; occupancy unchanged.
// - Pointers wrap modulo DEPTH; occupancy counter is width $clog2(DEPTH)+1.
// - Reset mid-packet discards the FIFO contents and the lock; no DONE is synthesised.
// TESTING
// - Reset, then ch0 pushes V(0xA1),V(0xA2),D(0xA3) with out_ready=1 -> out_valid at cycle 2 after first push; out_ch 0; beats in order; FSM returns ARB.
// - ch0 and ch2 each hold a 3-beat packet, pushed in the same cycle -> all ch0 beats, then all ch2 beats; no interleave.
// - Next ch0/ch2 contention after that -> ch2 follows ch0 per rr pointer.
// - out_ready=0 for 10 cycles with ch1 streaming -> out_* stable; in_ready[1] drops after DEPTH+1 beats accepted.
// - Release out_ready -> no loss or duplication.
// - ch3 pushes V(0x5) then stalls, TIMEOUT=8 -> err_timeout pulses once after 8 empty cycles.
// - Pending ch1 packet is granted the next cycle; late ch3 D(0x6) later appears as its own packet.
// - ch1 pushes in_cycle=IDLE or 2'd3 with in_valid=1 -> err_drop[1] pulses; FIFO level unchanged.
// - Assert rst_n=0 mid-burst with 2 beats queued -> outputs return to reset values immediately; first grant after release is ch0.

Source files
------------

// File: rtl/hero_burst_arbiter.sv
// hero_burst_arbiter
//   Merges NUM_CH hero write streams onto one registered hero output bus.
//   Each channel has its own DEPTH-entry FIFO. A round-robin arbiter picks
//   whole packets, so a packet (VALID beats closed by a DONE beat) is never
//   interleaved with another. A locked channel that stays empty for TIMEOUT
//   cycles is force-released, and the rest of its packet arbitrates again later.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      per-channel beat valid
//   in_ready      per-channel FIFO not full
//   in_data       per-channel payload, channel i at [i*DATA_W +: DATA_W]
//   in_cycle      per-channel CYCLE_TYPE (IDLE=0, VALID=1, DONE=2, 3 reserved)
//   out_valid     output beat valid
//   out_ready     downstream accept
//   out_data      output payload
//   out_cycle     output CYCLE_TYPE (VALID or DONE)
//   out_ch        source channel of the output beat
//   err_drop      per-channel pulse: accepted beat with IDLE/reserved type was discarded
//   err_timeout   pulse: lock was force-released by the idle timeout
module hero_burst_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH*2-1:0]      in_cycle,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               out_cycle,
    output logic [CH_W-1:0]          out_ch,
    output logic [NUM_CH-1:0]        err_drop,
    output logic                     err_timeout
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);

    localparam logic [1:0] CYC_IDLE  = 2'd0;
    localparam logic [1:0] CYC_VALID = 2'd1;
    localparam logic [1:0] CYC_DONE  = 2'd2;

    typedef enum logic {ARB, BURST} state_t;

    // FIFO entry: {done flag, payload}. VALID/DONE are the only stored types.
    logic [DATA_W:0]    mem    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]   wr_ptr [NUM_CH];
    logic [PTR_W-1:0]   rd_ptr [NUM_CH];
    logic [CNT_W-1:0]   count  [NUM_CH];
    logic [NUM_CH-1:0]  fifo_empty, push, drop, pop;

    state_t             state, state_next;
    logic [CH_W-1:0]    lock_ch, lock_next;
    logic [CH_W-1:0]    rr_ptr;
    logic [TO_W-1:0]    idle_cnt, idle_next;
    logic [CH_W-1:0]    grant_ch, sel_ch;
    logic               grant_found, pop_en, timeout_fire, can_load;
    logic [DATA_W:0]    head;
    logic               head_done;

    // ---------------- input side ----------------
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned (no latch).
    always_comb begin
        in_ready   = '0;
        fifo_empty = '0;
        push       = '0;
        drop       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i]   = (count[i] != FULL_CNT);
            fifo_empty[i] = (count[i] == '0);
            if (in_valid[i] && in_ready[i]) begin
                if (in_cycle[2*i +: 2] == CYC_VALID || in_cycle[2*i +: 2] == CYC_DONE)
                    push[i] = 1'b1;
                else
                    drop[i] = 1'b1;
            end
        end
    end

    // NOTE: storage carries no reset; occupancy counters alone decide what is
    // valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i])
                mem[i][wr_ptr[i]] <= {(in_cycle[2*i +: 2] == CYC_DONE), in_data[i*DATA_W +: DATA_W]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
                else if (!push[i] && pop[i]) count[i] <= count[i] - CNT_W'(1);
            end
        end
    end

    // ---------------- arbitration ----------------
    // First non-empty channel strictly after rr_ptr, wrapping NUM_CH-1 -> 0.
    always_comb begin
        logic [CH_W:0] cand;
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = {1'b0, rr_ptr} + (CH_W + 1)'(k);
            if (cand >= NUM_CH_V) cand = cand - NUM_CH_V;
            if (!grant_found && !fifo_empty[cand[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant_ch    = cand[CH_W-1:0];
            end
        end
    end

    assign can_load  = !out_valid || out_ready;
    assign sel_ch    = (state == BURST) ? lock_ch : grant_ch;
    assign head      = mem[sel_ch][rd_ptr[sel_ch]];
    assign head_done = head[DATA_W];

    always_comb begin
        state_next   = state;
        lock_next    = lock_ch;
        idle_next    = idle_cnt;
        pop_en       = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            ARB: begin
                if (can_load && grant_found) begin
                    pop_en    = 1'b1;
                    idle_next = '0;
                    if (!head_done) begin
                        state_next = BURST;
                        lock_next  = grant_ch;
                    end
                end
            end
            BURST: begin
                if (!fifo_empty[lock_ch]) begin
                    if (can_load) begin
                        pop_en    = 1'b1;
                        idle_next = '0;
                        if (head_done) state_next = ARB;
                    end
                end else if (TIMEOUT != 0) begin
                    if (idle_cnt == TO_LAST) begin
                        timeout_fire = 1'b1;
                        idle_next    = '0;
                        state_next   = ARB;
                    end else begin
                        idle_next = idle_cnt + TO_W'(1);
                    end
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++)
            pop[i] = pop_en && (sel_ch == CH_W'(i));
    end

    // ---------------- state and output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB;
            lock_ch     <= '0;
            rr_ptr      <= CH_W'(NUM_CH - 1);
            idle_cnt    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_cycle   <= CYC_IDLE;
            out_ch      <= '0;
            err_drop    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            lock_ch     <= lock_next;
            idle_cnt    <= idle_next;
            err_drop    <= drop;
            err_timeout <= timeout_fire;
            if (pop_en && state == ARB) rr_ptr <= grant_ch;
            if (pop_en) begin
                out_valid <= 1'b1;
                out_data  <= head[DATA_W-1:0];
                out_cycle <= head_done ? CYC_DONE : CYC_VALID;
                out_ch    <= sel_ch;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hero_burst_arbiter.sv
// Directed bench for hero_burst_arbiter (NUM_CH=4, DATA_W=32, DEPTH=4, TIMEOUT=8).
// A monitor records every accepted output beat; each scenario lists the beats
// it expects and compares them in order.
module tb_hero_burst_arbiter;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] V    = 2'd1;
    localparam logic [1:0] D    = 2'd2;
    localparam logic [1:0] RSV  = 2'd3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH*2-1:0]      in_cycle;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [1:0]               out_cycle;
    logic [1:0]               out_ch;
    logic [NUM_CH-1:0]        err_drop;
    logic                     err_timeout;

    int total = 0;
    int bad   = 0;

    logic [35:0] got_q[$];
    logic [35:0] exp_q[$];

    hero_burst_arbiter #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cycle(in_cycle),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_cycle(out_cycle), .out_ch(out_ch),
        .err_drop(err_drop), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && out_valid && out_ready)
            got_q.push_back({out_ch, out_cycle, out_data});

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [35:0] bt(input int ch, input logic [1:0] c, input logic [31:0] d);
        logic [1:0] chb;
        chb = ch[1:0];
        return {chb, c, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        in_valid = '0;
        in_cycle = '0;
        in_data  = '0;
    endtask

    task automatic set_in(input int ch, input logic [1:0] c, input logic [31:0] d);
        in_valid[ch]            = 1'b1;
        in_cycle[2*ch +: 2]     = c;
        in_data[ch*DATA_W +: DATA_W] = d;
    endtask

    // Wait (bounded) for the expected number of beats, allow a few extra
    // cycles to expose duplicates, then compare in order.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 200) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        logic will_acc;

        rst_n     = 1'b0;
        out_ready = 1'b1;
        clr_in();
        tick();
        tick();
        check("rst_out", {out_valid, out_ch, out_cycle, out_data}, 37'h0);
        check("rst_in_ready", in_ready, 4'hF);
        check("rst_err", {err_drop, err_timeout}, 5'h0);
        rst_n = 1'b1;
        tick();

        // ---- single ch0 packet, latency N+2 ----
        clr_in(); set_in(0, V, 32'hA1); tick();
        check("lat_n1_valid", out_valid, 1'b0);
        clr_in(); set_in(0, V, 32'hA2); tick();
        check("lat_n2", {out_valid, out_ch, out_cycle, out_data}, {1'b1, 2'd0, V, 32'hA1});
        clr_in(); set_in(0, D, 32'hA3); tick();
        clr_in();
        exp_q.push_back(bt(0, V, 32'hA1));
        exp_q.push_back(bt(0, V, 32'hA2));
        exp_q.push_back(bt(0, D, 32'hA3));
        drain("t1");

        // ---- contention with rr pointer at 0: ch2 wins, then ch0 ----
        for (int b = 0; b < 3; b++) begin
            clr_in();
            set_in(0, (b == 2) ? D : V, 32'hB0 + 32'(b));
            set_in(2, (b == 2) ? D : V, 32'hC0 + 32'(b));
            tick();
        end
        clr_in();
        for (int b = 0; b < 3; b++) exp_q.push_back(bt(2, (b == 2) ? D : V, 32'hC0 + 32'(b)));
        for (int b = 0; b < 3; b++) exp_q.push_back(bt(0, (b == 2) ? D : V, 32'hB0 + 32'(b)));
        drain("rr");

        // ---- contention after reset: ch0 first, no interleave ----
        do_reset();
        for (int b = 0; b < 3; b++) begin
            clr_in();
            set_in(0, (b == 2) ? D : V, 32'hD0 + 32'(b));
            set_in(2, (b == 2) ? D : V, 32'hE0 + 32'(b));
            tick();
        end
        clr_in();
        for (int b = 0; b < 3; b++) exp_q.push_back(bt(0, (b == 2) ? D : V, 32'hD0 + 32'(b)));
        for (int b = 0; b < 3; b++) exp_q.push_back(bt(2, (b == 2) ? D : V, 32'hE0 + 32'(b)));
        drain("contend");

        // ---- back-pressure: ch1 streams while out_ready=0 for 10 cycles ----
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            clr_in();
            if (k < 6) set_in(1, (k == 5) ? D : V, 32'h100 + 32'(k));
            will_acc = in_ready[1] && (k < 6);
            tick();
            if (will_acc) k++;
            if (c >= 1)
                check($sformatf("stall_hold%0d", c), {out_valid, out_ch, out_cycle, out_data},
                      {1'b1, 2'd1, V, 32'h100});
        end
        check("stall_accepted", 64'(k), 64'd5);
        check("stall_in_ready", in_ready[1], 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 50 && k < 6; c++) begin
            clr_in();
            set_in(1, (k == 5) ? D : V, 32'h100 + 32'(k));
            will_acc = in_ready[1];
            tick();
            if (will_acc) k++;
        end
        clr_in();
        for (int b = 0; b < 6; b++) exp_q.push_back(bt(1, (b == 5) ? D : V, 32'h100 + 32'(b)));
        drain("stall");

        // ---- timeout: ch3 locks then stalls; ch1 packet waits ----
        clr_in(); set_in(3, V, 32'h5); tick();
        for (int n = 2; n <= 16; n++) begin
            clr_in();
            if (n == 2) set_in(1, V, 32'h11);
            if (n == 3) set_in(1, D, 32'h12);
            tick();
            check($sformatf("timeout_e%0d", n), err_timeout, (n == 10));
            if (n == 11) check("timeout_grant", {out_valid, out_ch, out_data}, {1'b1, 2'd1, 32'h11});
        end
        clr_in(); set_in(3, D, 32'h6); tick();
        clr_in();
        exp_q.push_back(bt(3, V, 32'h5));
        exp_q.push_back(bt(1, V, 32'h11));
        exp_q.push_back(bt(1, D, 32'h12));
        exp_q.push_back(bt(3, D, 32'h6));
        drain("timeout");

        // ---- illegal cycle types are dropped ----
        clr_in(); set_in(1, IDLE, 32'hDEAD); tick();
        check("drop_idle", err_drop, 4'b0010);
        clr_in(); set_in(1, RSV, 32'hBEEF); tick();
        check("drop_rsv", err_drop, 4'b0010);
        clr_in(); tick();
        check("drop_clear", err_drop, 4'b0000);
        check("drop_in_ready", in_ready, 4'hF);
        set_in(1, D, 32'h77); tick();
        clr_in();
        exp_q.push_back(bt(1, D, 32'h77));
        drain("drop");

        // ---- reset mid-burst with two beats queued ----
        out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            clr_in(); set_in(0, V, 32'h31 + 32'(b)); tick();
        end
        clr_in();
        check("prerst_out", {out_valid, out_ch, out_data}, {1'b1, 2'd0, 32'h31});
        rst_n = 1'b0;
        #1;
        check("midrst_out", {out_valid, out_ch, out_cycle, out_data}, 37'h0);
        check("midrst_in_ready", in_ready, 4'hF);
        got_q.delete();
        exp_q.delete();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        set_in(2, D, 32'h41);
        set_in(0, D, 32'h40);
        tick();
        clr_in();
        exp_q.push_back(bt(0, D, 32'h40));
        exp_q.push_back(bt(2, D, 32'h41));
        drain("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
